// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that shares one i2c master between NUM_REQ requesters,
// holding the master for a fixed TXN_CYCLES window per transaction.
module i2c_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int TXN_CYCLES = 200,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [7*NUM_REQ-1:0]  req_slave_address,
  input  logic [NUM_REQ-1:0]    req_read_write,
  input  logic [8*NUM_REQ-1:0]  req_register_address,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           rd_data,
  output logic                  busy,
  output logic                  i2c_en,
  output logic [6:0]            i2c_slave_address,
  output logic                  i2c_read_write,
  output logic [7:0]            i2c_register_address,
  output logic [31:0]           i2c_data,
  input  logic [31:0]           i2c_data_out
);
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_req_chk
    $error("NUM_REQ must be at least 2");
  end
  if (TXN_CYCLES < 1 || TXN_CYCLES >= (1 << CNT_W)) begin : g_cnt_chk
    $error("TXN_CYCLES must be in [1, 2^CNT_W)");
  end

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t               state_q;
  logic [IW-1:0]        ptr_q, win_q, win_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_REQ-1:0]   grant_q, done_q;
  logic [31:0]          rd_q, data_q;
  logic                 busy_q, en_q, rw_q, found;
  logic [6:0]           sa_q;
  logic [7:0]           ra_q;
  int                   idx, win_i;

  // first requester with req set, scanning upward from the pointer
  always_comb begin
    found = 1'b0;
    win_i = int'(ptr_q);
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win_i = idx;
      end
    end
    win_d = IW'(win_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      sa_q    <= '0;
      rw_q    <= 1'b0;
      ra_q    <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (found) begin
            win_q   <= win_d;
            grant_q <= NUM_REQ'(1) << win_d;
            busy_q  <= 1'b1;
            sa_q    <= req_slave_address[7*win_i +: 7];
            rw_q    <= req_read_write[win_i];
            ra_q    <= req_register_address[8*win_i +: 8];
            data_q  <= req_data[32*win_i +: 32];
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          en_q    <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CNT_W'(TXN_CYCLES - 1)) ? S_DONE : S_WAIT;
        end
        S_DONE: begin
          done_q  <= grant_q;
          rd_q    <= rw_q ? i2c_data_out : rd_q;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant                = grant_q;
  assign done                 = done_q;
  assign rd_data              = rd_q;
  assign busy                 = busy_q;
  assign i2c_en               = en_q;
  assign i2c_slave_address    = sa_q;
  assign i2c_read_write       = rw_q;
  assign i2c_register_address = ra_q;
  assign i2c_data             = data_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed self-checking bench for i2c_arbiter with TXN_CYCLES=8.
module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int TXN = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [7*N-1:0]  req_slave_address = '0;
  logic [N-1:0]    req_read_write = '0;
  logic [8*N-1:0]  req_register_address = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]    grant, done;
  logic [31:0]     rd_data, i2c_data, i2c_data_out = '0;
  logic            busy, i2c_en, i2c_read_write;
  logic [6:0]      i2c_slave_address;
  logic [7:0]      i2c_register_address;

  int checks = 0, errors = 0, cyc = 0;
  int g_cyc, en_cyc, done_cyc, en_n, bad, prev_en;
  logic [N-1:0] exp_g;

  i2c_arbiter #(.NUM_REQ(N), .TXN_CYCLES(TXN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_slave_address(req_slave_address), .req_read_write(req_read_write),
    .req_register_address(req_register_address), .req_data(req_data),
    .grant(grant), .done(done), .rd_data(rd_data), .busy(busy), .i2c_en(i2c_en),
    .i2c_slave_address(i2c_slave_address), .i2c_read_write(i2c_read_write),
    .i2c_register_address(i2c_register_address), .i2c_data(i2c_data),
    .i2c_data_out(i2c_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic rw,
                         input logic [7:0] r, input logic [31:0] d);
    req_slave_address[7*i +: 7]     = a;
    req_read_write[i]               = rw;
    req_register_address[8*i +: 8]  = r;
    req_data[32*i +: 32]            = d;
    req[i]                          = 1'b1;
  endtask

  // waits (bounded) for a done pulse; tracks en pulses and grant stability meanwhile
  task automatic wait_done(input logic [N-1:0] g);
    en_cyc = -1;
    done_cyc = -1;
    en_n = 0;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      tick;
      if (i2c_en) begin
        en_n++;
        if (en_cyc < 0) en_cyc = cyc;
      end
      if (done != '0) begin
        done_cyc = cyc;
        break;
      end
      if (grant !== g) bad++;
    end
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("grant_hold", 64'(bad), 64'd0);
  endtask

  initial begin
    // reset state
    tick;
    tick;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_en", i2c_en, 0);
    check("rst_done", done, 0);
    check("rst_rd", rd_data, 0);
    check("rst_sa", i2c_slave_address, 0);
    rst = 1'b0;
    tick;

    // single write from requester 0
    set_req(0, 7'h63, 1'b0, 8'h0b, 32'h58ae1234);
    tick;
    g_cyc = cyc;
    check("w_grant", grant, 4'b0001);
    check("w_busy", busy, 1);
    check("w_sa", i2c_slave_address, 7'h63);
    check("w_rw", i2c_read_write, 0);
    check("w_ra", i2c_register_address, 8'h0b);
    check("w_data", i2c_data, 32'h58ae1234);
    check("w_en0", i2c_en, 0);
    wait_done(4'b0001);
    check("w_en_lat", 64'(en_cyc - g_cyc), 64'd1);
    check("w_en_n", 64'(en_n), 64'd1);
    check("w_done_lat", 64'(done_cyc - g_cyc), 64'd10);
    check("w_done", done, 4'b0001);
    check("w_rd", rd_data, 0);
    req[0] = 1'b0;
    tick;
    check("w_idle_busy", busy, 0);
    check("w_idle_done", done, 0);
    check("w_hold_sa", i2c_slave_address, 7'h63);

    // single read from requester 2
    set_req(2, 7'h63, 1'b1, 8'h0f, 32'h0);
    i2c_data_out = 32'hdeadbeef;
    tick;
    g_cyc = cyc;
    check("r_grant", grant, 4'b0100);
    check("r_rw", i2c_read_write, 1);
    check("r_ra", i2c_register_address, 8'h0f);
    wait_done(4'b0100);
    check("r_done_lat", 64'(done_cyc - g_cyc), 64'd10);
    check("r_done", done, 4'b0100);
    check("r_rd", rd_data, 32'hdeadbeef);
    req[2] = 1'b0;
    tick;

    // write after read keeps rd_data
    set_req(3, 7'h11, 1'b0, 8'h22, 32'h1);
    i2c_data_out = 32'h12345678;
    tick;
    check("wr_grant", grant, 4'b1000);
    wait_done(4'b1000);
    check("wr_done", done, 4'b1000);
    check("wr_rd_keep", rd_data, 32'hdeadbeef);
    req[3] = 1'b0;
    tick;

    // all four from reset release
    rst = 1'b1;
    tick;
    for (int i = 0; i < N; i++) set_req(i, 7'(7'h20 + i), 1'b0, 8'(8'h10 + i), 32'(i));
    rst = 1'b0;
    tick;
    prev_en = 0;
    for (int i = 0; i < N; i++) begin
      exp_g = N'(1) << i;
      g_cyc = cyc;
      check("all_grant", grant, exp_g);
      check("all_ra", i2c_register_address, 64'(8'h10 + i));
      wait_done(exp_g);
      check("all_done", done, exp_g);
      check("all_done_lat", 64'(done_cyc - g_cyc), 64'd10);
      if (i > 0) check("all_en_gap", 64'(en_cyc - prev_en), 64'd11);
      prev_en = en_cyc;
      req[i] = 1'b0;
      tick;
    end
    check("all_rd", rd_data, 0);

    // fairness: 0 and 3 held continuously
    set_req(0, 7'h01, 1'b0, 8'h00, 32'h0);
    set_req(3, 7'h03, 1'b0, 8'h03, 32'h3);
    tick;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 4'b1000 : 4'b0001;
      check("fair_grant", grant, exp_g);
      wait_done(exp_g);
      check("fair_done", done, exp_g);
      if (k == 3) req = '0;
      tick;
    end
    check("fair_idle", grant, 0);

    // reset mid-WAIT with counter at 4
    set_req(2, 7'h05, 1'b0, 8'h05, 32'h5);
    tick;
    check("rw_grant", grant, 4'b0100);
    repeat (5) tick;
    rst = 1'b1;
    #1;
    check("ar_grant", grant, 0);
    check("ar_busy", busy, 0);
    check("ar_en", i2c_en, 0);
    check("ar_done", done, 0);
    check("ar_data", i2c_data, 0);
    req = '0;
    tick;
    tick;
    check("ar_nodone", done, 0);
    set_req(1, 7'h07, 1'b0, 8'h07, 32'h7);
    rst = 1'b0;
    tick;
    g_cyc = cyc;
    check("ar2_grant", grant, 4'b0010);
    wait_done(4'b0010);
    check("ar2_done", done, 4'b0010);
    check("ar2_done_lat", 64'(done_cyc - g_cyc), 64'd10);
    check("ar2_en_n", 64'(en_n), 64'd1);
    req[1] = 1'b0;
    tick;

    // req dropped two cycles after grant
    set_req(1, 7'h09, 1'b0, 8'h09, 32'h9);
    tick;
    g_cyc = cyc;
    check("drop_grant", grant, 4'b0010);
    tick;
    tick;
    req[1] = 1'b0;
    wait_done(4'b0010);
    check("drop_done", done, 4'b0010);
    check("drop_done_lat", 64'(done_cyc - g_cyc), 64'd10);
    repeat (3) tick;
    check("drop_busy", busy, 0);
    check("drop_grant0", grant, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
